// File: rtl/count_sweep_ctrl_if.sv
// Control bus between count_sweep_ctrl and the 4-bit up/down counter.
//   load    : parallel-load datain into the counter
//   ce      : count enable
//   dir     : 0 = count up, 1 = count down
//   datain  : value loaded when load is high
//   cuenta  : counter output, read back by the controller
// master = controller side, slave = counter side.
interface count_sweep_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic             ce;
  logic             dir;
  logic [WIDTH-1:0] datain;
  logic [WIDTH-1:0] cuenta;

  modport master (
    output load,
    output ce,
    output dir,
    output datain,
    input  cuenta
  );

  modport slave (
    input  load,
    input  ce,
    input  dir,
    input  datain,
    output cuenta
  );
endinterface

// File: rtl/count_sweep_ctrl.sv
// Sweep controller for the 4-bit up/down counter. After an accepted start it
// loads the counter with lim_lo, then sweeps lim_lo -> lim_hi -> lim_lo for the
// requested number of passes, checking the counter output against a shadow
// count on every cycle and aborting with a sticky err on any disagreement.
// Ports:
//   clk     : rising-edge clock shared with the counter
//   reset   : asynchronous, active-low; clears all state
//   start   : sweep request, honoured only while idle
//   lim_lo  : lower bound, latched on accepted start
//   lim_hi  : upper bound, latched on accepted start
//   passes  : number of full lo->hi->lo passes, latched on accepted start
//   cnt     : counter control bus (load/ce/dir/datain out, cuenta in)
//   busy    : high from accepted start until done or abort
//   done    : one-cycle pulse when the final pass completes
//   err     : sticky error, cleared by reset or by the next accepted start
module count_sweep_ctrl #(
  parameter int WIDTH  = 4,
  parameter int CE_DIV = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   lim_lo,
  input  logic [WIDTH-1:0]   lim_hi,
  input  logic [3:0]         passes,
  count_sweep_ctrl_if.master cnt,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHK,
    UP,
    DOWN,
    DONE
  } state_t;

  localparam logic [7:0]       PRE_LAST = 8'(CE_DIV - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [3:0]       pass_q;
  logic [WIDTH-1:0] exp_q;
  logic [7:0]       pre_q;
  logic [7:0]       pre_nxt;

  // pre_q is the position of the current cycle inside the ce period; ce is
  // registered, so it is computed from the position of the next cycle.
  always_comb begin
    pre_nxt = (pre_q == PRE_LAST) ? 8'd0 : pre_q + 8'd1;
  end

  // Single FSM with registered outputs. exp_q follows the counter on the same
  // edge the counter acts on load/ce, so cuenta must equal exp_q every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lo_q       <= '0;
      hi_q       <= '0;
      pass_q     <= '0;
      exp_q      <= '0;
      pre_q      <= '0;
      cnt.load   <= 1'b0;
      cnt.ce     <= 1'b0;
      cnt.dir    <= 1'b0;
      cnt.datain <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      cnt.load <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lo_q   <= lim_lo;
            hi_q   <= lim_hi;
            pass_q <= passes;
            err    <= 1'b0;
            // An empty range or zero passes is rejected without touching the
            // counter; wrap-around can therefore never be commanded.
            if ((lim_lo >= lim_hi) || (passes == 4'd0)) begin
              err <= 1'b1;
            end else begin
              state      <= LOAD;
              busy       <= 1'b1;
              cnt.load   <= 1'b1;
              cnt.datain <= lim_lo;
              exp_q      <= lim_lo;
            end
          end
        end

        LOAD: begin
          state <= CHK;
        end

        CHK, UP, DOWN: begin
          if (cnt.cuenta != exp_q) begin
            err    <= 1'b1;
            busy   <= 1'b0;
            cnt.ce <= 1'b0;
            state  <= IDLE;
          end else if (state == CHK) begin
            // Prescaler restarts here so the first ce lands CE_DIV cycles
            // into UP.
            state   <= UP;
            cnt.dir <= 1'b0;
            pre_q   <= 8'd0;
            cnt.ce  <= (PRE_LAST == 8'd0);
          end else begin
            pre_q  <= pre_nxt;
            cnt.ce <= (pre_nxt == PRE_LAST);
            if (cnt.ce) begin
              if (state == UP) begin
                exp_q <= exp_q + ONE;
                if (exp_q == hi_q - ONE) begin
                  state   <= DOWN;
                  cnt.dir <= 1'b1;
                end
              end else begin
                exp_q <= exp_q - ONE;
                if (exp_q == lo_q + ONE) begin
                  pass_q <= pass_q - 4'd1;
                  if (pass_q == 4'd1) begin
                    state  <= DONE;
                    cnt.ce <= 1'b0;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                  end else begin
                    state   <= UP;
                    cnt.dir <= 1'b0;
                  end
                end
              end
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_sweep_ctrl.sv
// Randomised scoreboard bench for count_sweep_ctrl with a behavioural
// up/down counter attached. Each accepted start is turned into a timeline of
// expected events (load, every ce with its direction, done) and level checks
// (busy/err at given cycles); a monitor compares them as the DUT acts.
module tb_count_sweep_ctrl;

  localparam int D = 3;

  localparam int K_LOAD = 0;
  localparam int K_CE   = 1;
  localparam int K_DONE = 2;
  localparam int L_BUSY = 3;
  localparam int L_ERR  = 4;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } item_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] lim_lo;
  logic [3:0] lim_hi;
  logic [3:0] passes;
  logic       busy;
  logic       done;
  logic       err;

  int    cyc = 0;
  int    next_idle = 0;
  int    last_accept = 0;
  bit    skip_en = 1'b0;
  int    total = 0;
  int    bad = 0;
  item_t evq[$];
  item_t lvq[$];

  count_sweep_ctrl_if #(.WIDTH(4)) bus ();

  count_sweep_ctrl #(
    .WIDTH (4),
    .CE_DIV(D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .lim_lo(lim_lo),
    .lim_hi(lim_hi),
    .passes(passes),
    .cnt   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural counter; skip_en makes it jump 3 -> 5 when counting up.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.cuenta <= 4'd0;
    end else if (bus.load) begin
      bus.cuenta <= bus.datain;
    end else if (bus.ce) begin
      if (bus.dir) bus.cuenta <= bus.cuenta - 4'd1;
      else if (skip_en && bus.cuenta == 4'd3) bus.cuenta <= 4'd5;
      else bus.cuenta <= bus.cuenta + 4'd1;
    end
  end

  task automatic checkOutput(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic popCompare(input int kind, input int val);
    item_t it;
    total++;
    if (evq.size() == 0) begin
      bad++;
      $display("[TB] FAIL unexpected_event: got kind=%0d val=%0d, want none (cycle %0d)",
               kind, val, cyc);
    end else begin
      it = evq.pop_front();
      if (it.kind != kind || it.cyc != cyc || it.val != val) begin
        bad++;
        $display("[TB] FAIL event: got kind=%0d val=%0d cycle=%0d, want kind=%0d val=%0d cycle=%0d",
                 kind, val, cyc, it.kind, it.val, it.cyc);
      end
    end
  endtask

  // Monitor: runs away from the active edge; cyc is the index of the last edge.
  always @(negedge clk) begin
    if (reset) begin
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        total++;
        bad++;
        $display("[TB] FAIL missed_event: got nothing, want kind=%0d val=%0d at cycle %0d",
                 evq[0].kind, evq[0].val, evq[0].cyc);
        void'(evq.pop_front());
      end
      if (bus.load) begin
        checkOutput("ce_with_load", int'(bus.ce), 0);
        popCompare(K_LOAD, int'(bus.datain));
      end
      if (bus.ce) popCompare(K_CE, int'(bus.dir));
      if (done) popCompare(K_DONE, 1);
      while (lvq.size() > 0 && lvq[0].cyc <= cyc) begin
        if (lvq[0].kind == L_BUSY) checkOutput("busy_level", int'(busy), lvq[0].val);
        else checkOutput("err_level", int'(err), lvq[0].val);
        void'(lvq.pop_front());
      end
    end
  end

  // Direction of the j-th count step (1-based) of a sweep with span L.
  function automatic int dirOf(input int j, input int L);
    return (((j - 1) % (2 * L)) >= L) ? 1 : 0;
  endfunction

  // Reference timeline for a start accepted on edge a. Step j of the sweep
  // shows ce in the cycle after edge a+1+j*D; done follows the last step.
  task automatic predict(input int a, input int lo, input int hi, input int np,
                         input bit skip);
    int L, N, jf, last, e, d;
    if (lo >= hi || np == 0) begin
      lvq.push_back('{a, L_BUSY, 0});
      lvq.push_back('{a, L_ERR, 1});
      next_idle = a + 1;
      return;
    end
    L  = hi - lo;
    N  = np * 2 * L;
    jf = (skip && lo <= 3 && 3 < hi) ? (3 - lo + 1) : 0;
    evq.push_back('{a, K_LOAD, lo});
    lvq.push_back('{a, L_BUSY, 1});
    lvq.push_back('{a, L_ERR, 0});
    last = (jf != 0) ? jf : N;
    for (int j = 1; j <= last; j++) evq.push_back('{a + 1 + j * D, K_CE, dirOf(j, L)});
    if (jf != 0) begin
      e = a + 3 + jf * D;
      if (D == 1) evq.push_back('{a + 2 + jf * D, K_CE, dirOf(jf + 1, L)});
      lvq.push_back('{e, L_BUSY, 0});
      lvq.push_back('{e, L_ERR, 1});
      next_idle = e + 1;
    end else begin
      d = a + 2 + N * D;
      evq.push_back('{d, K_DONE, 1});
      lvq.push_back('{d, L_BUSY, 0});
      lvq.push_back('{d, L_ERR, 0});
      next_idle = d + 2;
    end
  endtask

  task automatic accept(input int lo, input int hi, input int np, input bit skip);
    last_accept = cyc + 1;
    skip_en     = skip;
    predict(last_accept, lo, hi, np, skip);
  endtask

  // Waits for the reference idle point, requests a sweep, and optionally keeps
  // start high while scrambling the limits until the next sweep is taken.
  task automatic applyStimulus(input int lo, input int hi, input int np,
                               input bit skip, input bit hold);
    int nlo;
    while (cyc + 1 < next_idle) @(negedge clk);
    lim_lo = 4'(lo);
    lim_hi = 4'(hi);
    passes = 4'(np);
    start  = 1'b1;
    accept(lo, hi, np, skip);
    @(negedge clk);
    if (hold) begin
      while (cyc + 1 < next_idle) begin
        nlo    = $urandom_range(0, 10);
        lim_lo = 4'(nlo);
        lim_hi = 4'(nlo + $urandom_range(1, 4));
        passes = 4'($urandom_range(1, 2));
        @(negedge clk);
      end
      accept(int'(lim_lo), int'(lim_hi), int'(passes), 1'b0);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_load"}, int'(bus.load), 0);
    checkOutput({tag, "_ce"}, int'(bus.ce), 0);
    checkOutput({tag, "_dir"}, int'(bus.dir), 0);
    checkOutput({tag, "_datain"}, int'(bus.datain), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, want finish within 20000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lo, hi, np;
    reset  = 1'b0;
    start  = 1'b0;
    lim_lo = 4'd0;
    lim_hi = 4'd0;
    passes = 4'd0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset     = 1'b1;
    next_idle = cyc + 1;

    applyStimulus(3, 7, 1, 1'b0, 1'b0);
    applyStimulus(0, 15, 2, 1'b0, 1'b0);
    applyStimulus(9, 9, 1, 1'b0, 1'b0);
    applyStimulus(5, 9, 0, 1'b0, 1'b0);
    applyStimulus(10, 4, 2, 1'b0, 1'b0);
    applyStimulus(2, 9, 1, 1'b1, 1'b0);
    applyStimulus(1, 4, 1, 1'b1, 1'b0);
    applyStimulus(6, 8, 1, 1'b0, 1'b0);

    // Reset in the fifth UP cycle of a sweep, then a clean restart.
    applyStimulus(4, 12, 2, 1'b0, 1'b0);
    while (cyc < last_accept + 6) @(negedge clk);
    evq.delete();
    lvq.delete();
    reset = 1'b0;
    #1;
    checkAllZero("midreset");
    repeat (2) @(negedge clk);
    reset     = 1'b1;
    next_idle = cyc + 1;
    applyStimulus(4, 12, 1, 1'b0, 1'b0);

    applyStimulus(2, 6, 1, 1'b0, 1'b1);

    for (int i = 0; i < 14; i++) begin
      lo = $urandom_range(0, 14);
      hi = $urandom_range(0, 15);
      if ($urandom_range(0, 3) != 0) hi = lo + $urandom_range(1, (15 - lo < 5) ? 15 - lo : 5);
      np = $urandom_range(0, 3);
      applyStimulus(lo, hi, np, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
    end

    while (cyc < next_idle + 4) @(negedge clk);
    checkOutput("pending_events", evq.size(), 0);
    checkOutput("pending_levels", lvq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
